serial_to_parallel: RTL

//   Receive side of the rotate/shift datapath: assembles a serial bit stream into WIDTH-bit words.

---
 rtl/s2p_defs_pkg.sv | 11 +
 rtl/s2p_bit_counter.sv | 28 ++
 rtl/serial_to_parallel.sv | 102 ++++++++++
 3 files changed

// File: rtl/s2p_defs_pkg.sv
// Shared definitions for the serial-to-parallel receiver: collector states and default word length.
package s2p_defs;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/s2p_bit_counter.sv
// Bits-received counter: synchronous clear beats enable, flags the last bit position of a word.
module s2p_bit_counter
    import s2p_defs::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CW    = $clog2(WIDTH)
) (
    input  logic          clk_i,
    input  logic          clear_i,
    input  logic          en_i,
    output logic [CW-1:0] count_o,
    output logic          tc_c_o
);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign count_o = count_q;
    assign tc_c_o  = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_to_parallel.sv
// Serial-to-parallel word collector with per-word bit order and a one-entry valid/ack output slot.
module serial_to_parallel
    import s2p_defs::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CW    = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_value,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             asright,
    input  logic             flush,
    input  logic             q_ack,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             busy,
    output logic [CW-1:0]    bit_count,
    output logic             overrun
);

    state_e           state_q;
    logic             dir_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] q_q;
    logic             q_valid_q;
    logic             overrun_q;

    logic             accept_c;
    logic             last_c;
    logic             complete_c;
    logic             dir_c;
    logic [WIDTH-1:0] base_c;
    logic [WIDTH-1:0] shifted_c;

    assign accept_c   = sin_valid & ~flush;
    assign complete_c = (state_q == S_SHIFT) & accept_c & last_c;

    // First bit of a word uses the live asright on an empty register; later bits use the latch.
    assign dir_c     = (state_q == S_IDLE) ? asright : dir_q;
    assign base_c    = (state_q == S_IDLE) ? '0 : sr_q;
    assign shifted_c = dir_c ? {sin, base_c[WIDTH-1:1]} : {base_c[WIDTH-2:0], sin};

    s2p_bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_counter (
        .clk_i   (clock),
        .clear_i (reset_value | flush | complete_c),
        .en_i    (accept_c),
        .count_o (bit_count),
        .tc_c_o  (last_c)
    );

    always_ff @(posedge clock) begin
        if (reset_value) begin
            state_q   <= S_IDLE;
            dir_q     <= 1'b0;
            sr_q      <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        state_q <= S_SHIFT;
                        dir_q   <= asright;
                        sr_q    <= shifted_c;
                    end
                end
                S_SHIFT: begin
                    if (flush || complete_c) begin
                        state_q <= S_IDLE;
                        sr_q    <= '0;
                    end else if (sin_valid) begin
                        sr_q <= shifted_c;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // Single-entry slot: a same-cycle ack makes room, otherwise the new word is lost.
            if (complete_c) begin
                if (!q_valid_q || q_ack) begin
                    q_q       <= shifted_c;
                    q_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (q_ack) begin
                q_valid_q <= 1'b0;
            end
        end
    end

    assign q         = q_q;
    assign q_valid   = q_valid_q;
    assign busy      = (state_q == S_SHIFT);
    assign overrun   = overrun_q;

endmodule
